// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types, reset value and default parameters for the reservation station
package rs_pkg;

  localparam int RS_NUM_ENTRIES  = 8;
  localparam int RS_NUM_CDB      = 2;
  localparam int RS_NUM_FU_TYPES = 4;
  localparam int RS_T_W          = 6;
  localparam int RS_FU_W         = $clog2(RS_NUM_FU_TYPES);

  // Functional-unit classes; one issue port each.
  typedef enum logic [RS_FU_W-1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_MEM = 2'd2,
    FU_BR  = 2'd3
  } FU_t;

  // Source operand tag: ready flag plus physical register index.
  typedef struct packed {
    logic              ready;
    logic [RS_T_W-1:0] idx;
  } T_t;

  // One reservation-station slot.
  typedef struct packed {
    logic              busy;
    FU_t               fu;
    logic [RS_T_W-1:0] T;
    T_t                T1;
    T_t                T2;
  } RS_ENTRY_t;

  // Value every slot takes on reset.
  localparam RS_ENTRY_t RS_RESET = '{
    busy: 1'b0,
    fu:   FU_ALU,
    T:    '0,
    T1:   '{ready: 1'b0, idx: '0},
    T2:   '{ready: 1'b0, idx: '0}
  };

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - one-hot grant of the oldest requesting entry using an age matrix
module rs_age_select #(
  parameter int NUM_ENTRIES = 8
) (
  input  logic [NUM_ENTRIES-1:0]             req,
  input  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] age,
  output logic [NUM_ENTRIES-1:0]             grant
);

  // An entry wins when no other requester is older than it (age[j*N+i] = j older than i).
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if ((j != i) && req[j] && age[j*NUM_ENTRIES + i]) begin
          grant[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rs_multi_issue.sv
// rtl/rs_multi_issue.sv - multi-issue reservation station with CDB wakeup, age-ordered select and flush
module rs_multi_issue
  import rs_pkg::*;
#(
  parameter int NUM_ENTRIES  = RS_NUM_ENTRIES,
  parameter int NUM_CDB      = RS_NUM_CDB,
  parameter int NUM_FU_TYPES = RS_NUM_FU_TYPES,
  parameter int T_W          = RS_T_W
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               flush,
  input  logic                               dispatch_en,
  input  logic [$clog2(NUM_FU_TYPES)-1:0]    dispatch_fu,
  input  logic [T_W-1:0]                     dispatch_T,
  input  logic [T_W:0]                       dispatch_T1,
  input  logic [T_W:0]                       dispatch_T2,
  input  logic [NUM_CDB-1:0]                 cdb_valid,
  input  logic [NUM_CDB*T_W-1:0]             cdb_T,
  input  logic [NUM_FU_TYPES-1:0]            fu_ready,
  output logic [NUM_FU_TYPES-1:0]            issue_valid,
  output logic [NUM_FU_TYPES*T_W-1:0]        issue_T,
  output logic [NUM_FU_TYPES*T_W-1:0]        issue_T1,
  output logic [NUM_FU_TYPES*T_W-1:0]        issue_T2,
  output logic                               full,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   free_count
);

  localparam int FW = $clog2(NUM_FU_TYPES);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int CW = $clog2(NUM_ENTRIES+1);

  // Entry storage, one field per array so every width follows the parameters.
  logic [NUM_ENTRIES-1:0] busy_q;
  logic [FW-1:0]          fu_q     [NUM_ENTRIES];
  logic [T_W-1:0]         tag_q    [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] t1_rdy_q;
  logic [NUM_ENTRIES-1:0] t2_rdy_q;
  logic [T_W-1:0]         t1_idx_q [NUM_ENTRIES];
  logic [T_W-1:0]         t2_idx_q [NUM_ENTRIES];
  // age_q[i*N+j] = 1 means entry i is older than entry j.
  logic [NUM_ENTRIES*NUM_ENTRIES-1:0] age_q;

  logic [NUM_ENTRIES-1:0] t1_woken;
  logic [NUM_ENTRIES-1:0] t2_woken;
  logic [NUM_ENTRIES-1:0] entry_ready;
  logic [NUM_ENTRIES-1:0] issued;
  logic [NUM_FU_TYPES-1:0][NUM_ENTRIES-1:0] grant_all;
  logic [IW-1:0]          slot;
  logic [CW-1:0]          free_cnt;
  logic                   dispatch_ok;
  logic                   d_t1_rdy;
  logic                   d_t2_rdy;

  function automatic logic cdb_hit(
    input logic [T_W-1:0]         idx,
    input logic [NUM_CDB-1:0]     v,
    input logic [NUM_CDB*T_W-1:0] t
  );
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (v[p] && (t[p*T_W +: T_W] == idx)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Operands count as woken when already ready or matched by a broadcast this cycle.
  always_comb begin
    t1_woken = t1_rdy_q;
    t2_woken = t2_rdy_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cdb_hit(t1_idx_q[i], cdb_valid, cdb_T)) t1_woken[i] = 1'b1;
      if (cdb_hit(t2_idx_q[i], cdb_valid, cdb_T)) t2_woken[i] = 1'b1;
    end
    entry_ready = busy_q & t1_woken & t2_woken;
  end

  genvar f;
  generate
    for (f = 0; f < NUM_FU_TYPES; f++) begin : g_fu
      logic [NUM_ENTRIES-1:0] req;
      logic [NUM_ENTRIES-1:0] grant;
      logic [T_W-1:0]         sel_t;
      logic [T_W-1:0]         sel_t1;
      logic [T_W-1:0]         sel_t2;

      // Ready entries belonging to this FU class.
      always_comb begin
        req = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          req[i] = entry_ready[i] && (fu_q[i] == FW'(f));
        end
      end

      rs_age_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_sel (
        .req   (req),
        .age   (age_q),
        .grant (grant)
      );

      // One-hot grant drives an AND-OR mux of the winning entry's tags.
      always_comb begin
        sel_t  = '0;
        sel_t1 = '0;
        sel_t2 = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (grant[i]) begin
            sel_t  = sel_t  | tag_q[i];
            sel_t1 = sel_t1 | t1_idx_q[i];
            sel_t2 = sel_t2 | t2_idx_q[i];
          end
        end
      end

      assign issue_valid[f]            = (|grant) && fu_ready[f] && en && !flush;
      assign issue_T [f*T_W +: T_W]    = sel_t;
      assign issue_T1[f*T_W +: T_W]    = sel_t1;
      assign issue_T2[f*T_W +: T_W]    = sel_t2;
      assign grant_all[f]              = grant & {NUM_ENTRIES{issue_valid[f]}};
    end
  endgenerate

  // Entries actually leaving the station this cycle, across all FU classes.
  always_comb begin
    issued = '0;
    for (int k = 0; k < NUM_FU_TYPES; k++) issued = issued | grant_all[k];
  end

  // Lowest free slot and free count, both from registered occupancy only.
  always_comb begin
    slot     = '0;
    free_cnt = '0;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (!busy_q[i]) slot = IW'(i);
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_cnt = free_cnt + CW'(!busy_q[i]);
    end
  end

  assign full        = &busy_q;
  assign free_count  = free_cnt;
  assign dispatch_ok = dispatch_en && en && !flush && !full;
  // Capture a broadcast that lands in the dispatch cycle so the wakeup is not lost.
  assign d_t1_rdy    = dispatch_T1[T_W] || cdb_hit(dispatch_T1[T_W-1:0], cdb_valid, cdb_T);
  assign d_t2_rdy    = dispatch_T2[T_W] || cdb_hit(dispatch_T2[T_W-1:0], cdb_valid, cdb_T);

  // Entry state: reset clears, flush empties, otherwise wakeup, retire issued entries, accept dispatch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q   <= {NUM_ENTRIES{RS_RESET.busy}};
      t1_rdy_q <= {NUM_ENTRIES{RS_RESET.T1.ready}};
      t2_rdy_q <= {NUM_ENTRIES{RS_RESET.T2.ready}};
      age_q    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        fu_q[i]     <= FW'(RS_RESET.fu);
        tag_q[i]    <= T_W'(RS_RESET.T);
        t1_idx_q[i] <= T_W'(RS_RESET.T1.idx);
        t2_idx_q[i] <= T_W'(RS_RESET.T2.idx);
      end
    end else if (flush) begin
      busy_q <= '0;
    end else if (en) begin
      t1_rdy_q <= t1_woken;
      t2_rdy_q <= t2_woken;
      busy_q   <= busy_q & ~issued;
      if (dispatch_ok) begin
        busy_q[slot]   <= 1'b1;
        fu_q[slot]     <= dispatch_fu;
        tag_q[slot]    <= dispatch_T;
        t1_rdy_q[slot] <= d_t1_rdy;
        t2_rdy_q[slot] <= d_t2_rdy;
        t1_idx_q[slot] <= dispatch_T1[T_W-1:0];
        t2_idx_q[slot] <= dispatch_T2[T_W-1:0];
        // New entry is younger than every entry currently occupied.
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          age_q[int'(slot)*NUM_ENTRIES + j] <= 1'b0;
          age_q[j*NUM_ENTRIES + int'(slot)] <= busy_q[j] && (j != int'(slot));
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_issue.sv
// tb/tb_rs_multi_issue.sv - vector table plus issue scoreboard for rs_multi_issue
module tb_rs_multi_issue;
  import rs_pkg::*;

  logic        clock;
  logic        reset;
  logic        en;
  logic        flush;
  logic        dispatch_en;
  logic [1:0]  dispatch_fu;
  logic [5:0]  dispatch_T;
  logic [6:0]  dispatch_T1;
  logic [6:0]  dispatch_T2;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_T;
  logic [3:0]  fu_ready;
  logic [3:0]  issue_valid;
  logic [23:0] issue_T;
  logic [23:0] issue_T1;
  logic [23:0] issue_T2;
  logic        full;
  logic [3:0]  free_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbq[$];
  logic [31:0] mon_got;
  logic [31:0] mon_exp;

  typedef struct packed {
    logic        d_en;
    logic [1:0]  d_fu;
    logic [5:0]  d_t;
    logic [6:0]  d_t1;
    logic [6:0]  d_t2;
    logic [1:0]  cv;
    logic [11:0] ct;
    logic [3:0]  fr;
    logic [3:0]  e_iv;
    logic [3:0]  e_free;
    logic        push;
    logic [31:0] pv;
  } vec_t;

  vec_t tbl [18];

  rs_multi_issue dut (
    .clock       (clock),
    .reset       (reset),
    .en          (en),
    .flush       (flush),
    .dispatch_en (dispatch_en),
    .dispatch_fu (dispatch_fu),
    .dispatch_T  (dispatch_T),
    .dispatch_T1 (dispatch_T1),
    .dispatch_T2 (dispatch_T2),
    .cdb_valid   (cdb_valid),
    .cdb_T       (cdb_T),
    .fu_ready    (fu_ready),
    .issue_valid (issue_valid),
    .issue_T     (issue_T),
    .issue_T1    (issue_T1),
    .issue_T2    (issue_T2),
    .full        (full),
    .free_count  (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] pk(input logic [1:0] fu, input logic [5:0] t,
                                     input logic [5:0] t1, input logic [5:0] t2);
    return {12'd0, fu, t, t1, t2};
  endfunction

  function automatic vec_t v(input logic d_en, input logic [1:0] fu, input logic [5:0] t,
                             input logic [6:0] t1, input logic [6:0] t2,
                             input logic [1:0] cv, input logic [11:0] ct, input logic [3:0] fr,
                             input logic [3:0] e_iv, input logic [3:0] e_free,
                             input logic push, input logic [31:0] pv);
    vec_t r;
    r.d_en = d_en; r.d_fu = fu; r.d_t = t; r.d_t1 = t1; r.d_t2 = t2;
    r.cv = cv; r.ct = ct; r.fr = fr; r.e_iv = e_iv; r.e_free = e_free;
    r.push = push; r.pv = pv;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    dispatch_en = 1'b0; dispatch_fu = 2'd0; dispatch_T = 6'd0;
    dispatch_T1 = 7'd0; dispatch_T2 = 7'd0;
    cdb_valid = 2'b00; cdb_T = 12'd0; fu_ready = 4'hF; en = 1'b1; flush = 1'b0;
  endtask

  task automatic next();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic disp(input logic [1:0] fu, input logic [5:0] t, input logic [6:0] t1,
                      input logic [6:0] t2);
    dispatch_en = 1'b1; dispatch_fu = fu; dispatch_T = t;
    dispatch_T1 = t1; dispatch_T2 = t2;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 24) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk(nm, 32'(sbq.size()), 32'd0);
    next();
    @(negedge clock);
    chk({nm, "_free"}, 32'(free_count), 32'd8);
    next();
  endtask

  // Scoreboard: every observed issue must match the next expected packet.
  always @(negedge clock) begin
    if (reset) begin
      for (int f = 0; f < 4; f++) begin
        if (issue_valid[f]) begin
          mon_got = pk(2'(f), issue_T[f*6 +: 6], issue_T1[f*6 +: 6], issue_T2[f*6 +: 6]);
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_issue: got %0h expected none", mon_got);
          end else begin
            mon_exp = sbq.pop_front();
            chk("issue_pkt", mon_got, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = v(1, FU_ALU, 6'd5,  {1'b0,6'd3},  {1'b1,6'd4},  2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[1]  = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b01, {6'd0,6'd3}, 4'hF, 4'b0001, 4'd7, 1, pk(FU_ALU,5,3,4));
    tbl[2]  = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[3]  = v(1, FU_ALU, 6'd6,  {1'b0,6'd7},  {1'b1,6'd1},  2'b10, {6'd7,6'd0}, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[4]  = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b0001, 4'd7, 1, pk(FU_ALU,6,7,1));
    tbl[5]  = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[6]  = v(1, FU_MUL, 6'd9,  {1'b1,6'd2},  {1'b1,6'd2},  2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[7]  = v(1, FU_MEM, 6'd10, {1'b0,6'd20}, {1'b0,6'd21}, 2'b11, {6'd21,6'd20}, 4'hF, 4'b0010, 4'd7, 1, pk(FU_MUL,9,2,2));
    tbl[8]  = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b0100, 4'd7, 1, pk(FU_MEM,10,20,21));
    tbl[9]  = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[10] = v(1, FU_ALU, 6'd11, {1'b0,6'd30}, {1'b1,6'd0},  2'b00, {6'd30,6'd30}, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[11] = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, {6'd30,6'd30}, 4'hF, 4'b0000, 4'd7, 0, 0);
    tbl[12] = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b01, {6'd0,6'd30},  4'hF, 4'b0001, 4'd7, 1, pk(FU_ALU,11,30,0));
    tbl[13] = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[14] = v(1, FU_BR,  6'd12, {1'b1,6'd1},  {1'b1,6'd1},  2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);
    tbl[15] = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'b0111, 4'b0000, 4'd7, 0, 0);
    tbl[16] = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b1000, 4'd7, 1, pk(FU_BR,12,1,1));
    tbl[17] = v(0, 2'd0,   6'd0,  7'd0,         7'd0,         2'b00, 12'd0, 4'hF, 4'b0000, 4'd8, 0, 0);

    reset = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_iv", 32'(issue_valid), 32'd0);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_free", 32'(free_count), 32'd8);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Table: single-cycle wakeup, dispatch-cycle capture, multi-FU, invalid CDB, backpressure.
    for (int r = 0; r < 18; r++) begin
      dispatch_en = tbl[r].d_en; dispatch_fu = tbl[r].d_fu; dispatch_T = tbl[r].d_t;
      dispatch_T1 = tbl[r].d_t1; dispatch_T2 = tbl[r].d_t2;
      cdb_valid = tbl[r].cv; cdb_T = tbl[r].ct; fu_ready = tbl[r].fr;
      if (tbl[r].push) sbq.push_back(tbl[r].pv);
      @(negedge clock);
      chk($sformatf("tbl%0d_iv", r), 32'(issue_valid), 32'(tbl[r].e_iv));
      chk($sformatf("tbl%0d_free", r), 32'(free_count), 32'(tbl[r].e_free));
      chk($sformatf("tbl%0d_full", r), 32'(full), 32'd0);
      next();
    end
    chk("tbl_sb_empty", 32'(sbq.size()), 32'd0);

    // Fill to full, dropped dispatch, full drops one cycle after the first issue.
    for (int i = 0; i < 8; i++) begin
      disp(FU_ALU, 6'(i), {1'b0,6'd40}, {1'b1,6'd0});
      @(negedge clock);
      chk("fill_free", 32'(free_count), 32'(8 - i));
      next();
    end
    disp(FU_ALU, 6'd50, {1'b1,6'd1}, {1'b1,6'd1});
    @(negedge clock);
    chk("full_set", 32'(full), 32'd1);
    chk("full_free0", 32'(free_count), 32'd0);
    next();
    disp(FU_ALU, 6'd50, {1'b1,6'd1}, {1'b1,6'd1});
    cdb_valid = 2'b01; cdb_T = {6'd0,6'd40};
    for (int i = 0; i < 8; i++) sbq.push_back(pk(FU_ALU, 6'(i), 6'd40, 6'd0));
    @(negedge clock);
    chk("full_issue_cycle", 32'(full), 32'd1);
    next();
    @(negedge clock);
    chk("full_clear", 32'(full), 32'd0);
    chk("free_after_issue", 32'(free_count), 32'd1);
    drain("fill_drain");

    // Age order differs from index order: A in slot1, B reuses slot0, C in slot2.
    fu_ready = 4'b1110; disp(FU_MUL, 6'd20, {1'b0,6'd60}, {1'b1,6'd0});
    next();
    fu_ready = 4'b1110; disp(FU_ALU, 6'd21, {1'b1,6'd1}, {1'b1,6'd1});
    next();
    fu_ready = 4'b1110; cdb_valid = 2'b01; cdb_T = {6'd0,6'd60};
    sbq.push_back(pk(FU_MUL, 6'd20, 6'd60, 6'd0));
    @(negedge clock);
    chk("age_x_issue", 32'(issue_valid), 32'b0010);
    next();
    fu_ready = 4'b1110; disp(FU_ALU, 6'd22, {1'b1,6'd2}, {1'b1,6'd2});
    next();
    fu_ready = 4'b1110; disp(FU_ALU, 6'd23, {1'b1,6'd3}, {1'b1,6'd3});
    next();
    for (int i = 0; i < 2; i++) begin
      fu_ready = 4'b1110;
      @(negedge clock);
      chk("alu_stalled", 32'(issue_valid), 32'd0);
      next();
    end
    sbq.push_back(pk(FU_ALU, 6'd21, 6'd1, 6'd1));
    sbq.push_back(pk(FU_ALU, 6'd22, 6'd2, 6'd2));
    sbq.push_back(pk(FU_ALU, 6'd23, 6'd3, 6'd3));
    drain("age_order");

    // Flush with en low, then a broadcast that must wake nothing.
    for (int i = 0; i < 5; i++) begin
      disp(FU_ALU, 6'(40 + i), {1'b0,6'd50}, {1'b1,6'd0});
      next();
    end
    flush = 1'b1; en = 1'b0;
    disp(FU_ALU, 6'd45, {1'b1,6'd1}, {1'b1,6'd1});
    cdb_valid = 2'b01; cdb_T = {6'd0,6'd50};
    @(negedge clock);
    chk("flush_no_issue", 32'(issue_valid), 32'd0);
    chk("flush_free", 32'(free_count), 32'd3);
    next();
    cdb_valid = 2'b01; cdb_T = {6'd0,6'd50};
    @(negedge clock);
    chk("post_flush_free", 32'(free_count), 32'd8);
    chk("post_flush_iv", 32'(issue_valid), 32'd0);
    next();

    // Freeze: dispatch ignored and issue withheld while en is low.
    en = 1'b0; disp(FU_ALU, 6'd46, {1'b1,6'd4}, {1'b1,6'd4});
    @(negedge clock);
    chk("freeze_iv", 32'(issue_valid), 32'd0);
    next();
    @(negedge clock);
    chk("freeze_free", 32'(free_count), 32'd8);
    next();
    fu_ready = 4'b1110; disp(FU_ALU, 6'd47, {1'b1,6'd5}, {1'b1,6'd5});
    next();
    en = 1'b0;
    @(negedge clock);
    chk("hold_iv", 32'(issue_valid), 32'd0);
    chk("hold_free", 32'(free_count), 32'd7);
    next();
    sbq.push_back(pk(FU_ALU, 6'd47, 6'd5, 6'd5));
    drain("hold_issue");

    // Asynchronous reset in the middle of traffic.
    fu_ready = 4'b1110; disp(FU_ALU, 6'd33, {1'b1,6'd6}, {1'b1,6'd6});
    next();
    fu_ready = 4'b1110; disp(FU_ALU, 6'd34, {1'b1,6'd7}, {1'b1,6'd7});
    @(negedge clock);
    chk("pre_rst_free", 32'(free_count), 32'd7);
    reset = 1'b0;
    #1;
    chk("rst_async_iv", 32'(issue_valid), 32'd0);
    chk("rst_async_full", 32'(full), 32'd0);
    chk("rst_async_free", 32'(free_count), 32'd8);
    idle();
    @(posedge clock);
    @(negedge clock);
    chk("rst_held_iv", 32'(issue_valid), 32'd0);
    chk("rst_held_free", 32'(free_count), 32'd8);
    reset = 1'b1;
    next();
    @(negedge clock);
    chk("post_rst_iv", 32'(issue_valid), 32'd0);
    chk("post_rst_free", 32'(free_count), 32'd8);
    next();
    next();
    chk("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
